// File: rtl/cache_axi_pkg.sv
// Shared types and helpers for the instruction-cache SRAM-to-AXI bridge.
// Holds the bridge FSM encoding, SRAM-like size codes and the write-strobe decode.
package cache_axi_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AW_W = 3'd3,
    B    = 3'd4
  } bridge_state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Size 3 is not a legal SRAM-like size; it falls back to a full word.
  function automatic logic [3:0] size_to_strb(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      SIZE_B:  strb = 4'b0001 << addr_lo;
      SIZE_H:  strb = 4'b0011 << {addr_lo[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// Turns the I-cache SRAM-like port into single-beat AXI reads/writes, one in flight.
// Read data returns combinationally on the R handshake cycle; valids hold until accepted.
module sram_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sram_req,
  input  logic                    sram_wr,
  input  logic [1:0]              sram_size,
  input  logic [ADDR_WIDTH-1:0]   sram_addr,
  input  logic [DATA_WIDTH-1:0]   sram_wdata,
  output logic [DATA_WIDTH-1:0]   sram_rdata,
  output logic                    sram_addr_ok,
  output logic                    sram_data_ok,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]              arsize,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awsize,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic                    bvalid,
  output logic                    bready
);

  bridge_state_t           state_q, state_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    wr_q, wr_d;
  logic [1:0]              size_q, size_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    aw_hs, w_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sram_addr_ok = 1'b0;
    sram_data_ok = 1'b0;
    sram_rdata   = '0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    aw_hs        = 1'b0;
    w_hs         = 1'b0;
    case (state_q)
      IDLE: begin
        sram_addr_ok = sram_req;
        if (sram_req) begin
          wr_d    = sram_wr;
          size_d  = sram_size;
          addr_d  = sram_addr;
          wdata_d = sram_wdata;
          state_d = sram_wr ? AW_W : AR;
        end
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) state_d = R;
      end
      R: begin
        rready = 1'b1;
        if (rvalid) begin
          sram_data_ok = 1'b1;
          sram_rdata   = rdata;
          state_d      = IDLE;
        end
      end
      AW_W: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        aw_hs   = awvalid && awready;
        w_hs    = wvalid && wready;
        // Address and data channels are independent; B waits for whichever finishes last.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = B;
        end else begin
          aw_done_d = aw_done_q || aw_hs;
          w_done_d  = w_done_q || w_hs;
        end
      end
      B: begin
        bready = 1'b1;
        if (bvalid) begin
          sram_data_ok = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign araddr = addr_q;
  assign arsize = {1'b0, size_q};
  assign awaddr = addr_q;
  assign awsize = {1'b0, size_q};
  assign wdata  = wdata_q;
  assign wstrb  = size_to_strb(size_q, addr_q[1:0]);

endmodule
